// File: rtl/ecc_lockstep_chk.sv
// Registered SECDED check stage with two lockstep decoders, saturating counters and a fault FSM.
// Define ECC_LOCKSTEP_INJ_EN to add the inj_mask_flip compare-path self-test port.
module ecc_lockstep_chk #(
   parameter int unsigned DATA_WIDTH   = 90,
   parameter int unsigned PARITY_WIDTH = 8,
   parameter int unsigned CNT_WIDTH    = 8,
   parameter int unsigned FAULT_THRESH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   input  logic                    bypass,
   input  logic                    ecc_fault_detc_en,
   input  logic                    clr,
`ifdef ECC_LOCKSTEP_INJ_EN
   input  logic                    inj_mask_flip,
`endif
   output logic                    valid_out,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    sbit_err,
   output logic                    dbit_err,
   output logic                    ecc_fault,
   output logic [1:0]              fault_state,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt
);

   localparam int unsigned HamW  = PARITY_WIDTH - 1;
   localparam int unsigned CodeW = DATA_WIDTH + HamW;
   localparam int unsigned VecW  = DATA_WIDTH + 2;

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   Thresh = (CNT_WIDTH + 1)'(FAULT_THRESH);

   typedef enum logic [1:0] {
      StOk       = 2'b00,
      StDegraded = 2'b01,
      StFailed   = 2'b10
   } state_e;

   // Returns {sbit, dbit, mask}. Hamming bit k sits at codeword position 2^k, data bits fill the
   // remaining positions in ascending order, and the top parity bit is overall parity.
   function automatic logic [VecW-1:0] secded_dec(input logic [DATA_WIDTH-1:0]   d,
                                                 input logic [PARITY_WIDTH-1:0] par,
                                                 input logic                    byp);
      logic [HamW-1:0]       syn;
      logic [DATA_WIDTH-1:0] mask;
      logic                  ovr;
      logic                  sbit;
      logic                  dbit;
      int unsigned           di;
      int unsigned           hi;
      syn = '0;
      mask = '0;
      di = 0;
      hi = 0;
      ovr = ^{d, par};
      for (int unsigned p = 1; p <= CodeW; p++) begin
         if ((p & (p - 1)) == 0) begin
            if (par[hi]) syn = syn ^ p[HamW-1:0];
            hi++;
         end else begin
            if (d[di]) syn = syn ^ p[HamW-1:0];
            di++;
         end
      end
      sbit = ovr;
      dbit = !ovr && (syn != '0);
      di = 0;
      for (int unsigned p = 1; p <= CodeW; p++) begin
         if ((p & (p - 1)) != 0) begin
            mask[di] = sbit && (syn == p[HamW-1:0]);
            di++;
         end
      end
      return byp ? '0 : {sbit, dbit, mask};
   endfunction

   logic [VecW-1:0]       vec0;
   logic [VecW-1:0]       vec1;
   logic                  miscmp;
   logic [DATA_WIDTH-1:0] corr_data;
   logic [DATA_WIDTH-1:0] sel_data;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] sbit_cnt_q, sbit_cnt_d;
   logic [CNT_WIDTH-1:0] dbit_cnt_q, dbit_cnt_d;
   logic [CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
   logic [CNT_WIDTH:0]   fault_cnt_inc;

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  sbit_q;
   logic                  dbit_q;
   logic                  fault_q;

   assign vec0 = secded_dec(data_in, parity_in, bypass);
`ifdef ECC_LOCKSTEP_INJ_EN
   assign vec1 = secded_dec(data_in, parity_in, bypass) ^ {{(VecW - 1){1'b0}}, inj_mask_flip};
`else
   assign vec1 = secded_dec(data_in, parity_in, bypass);
`endif

   assign miscmp        = ecc_fault_detc_en && (vec0 != vec1);
   assign corr_data     = data_in ^ vec0[DATA_WIDTH-1:0];
   assign fault_cnt_inc = {1'b0, fault_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      state_d     = state_q;
      sbit_cnt_d  = sbit_cnt_q;
      dbit_cnt_d  = dbit_cnt_q;
      fault_cnt_d = fault_cnt_q;
      if (clr) begin
         state_d     = StOk;
         sbit_cnt_d  = '0;
         dbit_cnt_d  = '0;
         fault_cnt_d = '0;
      end else if (valid_in) begin
         if (vec0[VecW-1] && (sbit_cnt_q != CntMax)) sbit_cnt_d = sbit_cnt_q + CntOne;
         if (vec0[VecW-2] && (dbit_cnt_q != CntMax)) dbit_cnt_d = dbit_cnt_q + CntOne;
         if (miscmp) begin
            if (fault_cnt_q != CntMax) fault_cnt_d = fault_cnt_q + CntOne;
            if (state_q != StFailed) begin
               state_d = (fault_cnt_inc >= Thresh) ? StFailed : StDegraded;
            end
         end
      end
   end

   // Correction gating follows the post-edge state so data_out agrees with fault_state.
   assign sel_data = (miscmp || (state_d == StFailed)) ? data_in : corr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StOk;
         sbit_cnt_q  <= '0;
         dbit_cnt_q  <= '0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sbit_cnt_q  <= sbit_cnt_d;
         dbit_cnt_q  <= dbit_cnt_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sbit_q  <= 1'b0;
         dbit_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_in;
         sbit_q  <= valid_in && vec0[VecW-1];
         dbit_q  <= valid_in && vec0[VecW-2];
         fault_q <= valid_in && miscmp;
         if (valid_in) data_q <= sel_data;
      end
   end

   assign valid_out   = valid_q;
   assign data_out    = data_q;
   assign sbit_err    = sbit_q;
   assign dbit_err    = dbit_q;
   assign ecc_fault   = fault_q;
   assign fault_state = state_q;
   assign sbit_cnt    = sbit_cnt_q;
   assign dbit_cnt    = dbit_cnt_q;
   assign fault_cnt   = fault_cnt_q;

endmodule
